// File: rtl/csi_rx_packet_parser.sv
// CSI-2 packet parser: header decode, CRC strip, payload byte enables.
// Sits between the word aligner and the ISP/unpacker.
module csi_rx_packet_parser #(
  parameter int NUM_LANE = 2
) (
  input  logic                  byte_clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [8*NUM_LANE-1:0] data_in,
  input  logic                  valid_in,
  output logic                  wait_for_sync,
  output logic                  packet_done,
  output logic                  hdr_valid,
  output logic [1:0]            virtual_channel,
  output logic [5:0]            data_type,
  output logic [15:0]           word_count,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic [8*NUM_LANE-1:0] payload_out,
  output logic [NUM_LANE-1:0]   payload_be,
  output logic                  payload_valid,
  output logic                  pkt_err
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hdr_q [3];
  logic [7:0]    hdr_d [3];
  logic [2:0]    hdr_cnt_q;
  logic [2:0]    hdr_cnt_d;
  logic [2:0]    idx;
  logic [17:0]   rem_q;
  logic          hdr_full;
  logic          is_long;
  logic          take_hdr;
  logic          decode;
  logic          take_pay;
  logic          abort;
  logic [NUM_LANE-1:0] be_d;

  assign wait_for_sync = (state_q == IDLE);
  assign packet_done   = (state_q == DONE);

  // ECC byte (header byte 3) is never stored
  always_comb begin
    hdr_d = hdr_q;
    idx   = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      idx = hdr_cnt_q + 3'(i);
      if (idx < 3'd3) begin
        hdr_d[idx[1:0]] = data_in[8*i +: 8];
      end
    end
  end

  assign hdr_cnt_d = hdr_cnt_q + 3'(NUM_LANE);
  assign hdr_full  = (hdr_cnt_d >= 3'd4);
  assign is_long   = (hdr_d[0][5:0] >= 6'h10);

  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      be_d[i] = (rem_q > 18'(i + 2));
    end
  end

  always_comb begin
    state_d  = state_q;
    take_hdr = 1'b0;
    decode   = 1'b0;
    take_pay = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE, HEADER: begin
        if (valid_in) begin
          take_hdr = 1'b1;
          if (hdr_full) begin
            decode  = 1'b1;
            state_d = is_long ? PAYLOAD : DONE;
          end else begin
            state_d = HEADER;
          end
        end else if (state_q == HEADER) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      PAYLOAD: begin
        if (valid_in) begin
          take_pay = 1'b1;
          if (rem_q <= 18'(NUM_LANE)) begin
            state_d = DONE;
          end
        end else begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      hdr_q           <= '{default: 8'h00};
      hdr_cnt_q       <= '0;
      rem_q           <= '0;
      hdr_valid       <= 1'b0;
      frame_start     <= 1'b0;
      frame_end       <= 1'b0;
      pkt_err         <= 1'b0;
      payload_valid   <= 1'b0;
      payload_out     <= '0;
      payload_be      <= '0;
      virtual_channel <= '0;
      data_type       <= '0;
      word_count      <= '0;
    end else if (enable) begin
      state_q       <= state_d;
      hdr_valid     <= decode;
      frame_start   <= decode && (hdr_d[0][5:0] == 6'h00);
      frame_end     <= decode && (hdr_d[0][5:0] == 6'h01);
      pkt_err       <= abort;
      payload_valid <= take_pay;
      hdr_cnt_q     <= (take_hdr && !hdr_full) ? hdr_cnt_d : 3'd0;
      if (take_hdr) begin
        hdr_q <= hdr_d;
      end
      if (decode) begin
        virtual_channel <= hdr_d[0][7:6];
        data_type       <= hdr_d[0][5:0];
        word_count      <= {hdr_d[2], hdr_d[1]};
        rem_q           <= {2'b00, hdr_d[2], hdr_d[1]} + 18'd2;
      end
      // rem saturates; the packet ends once it reaches NUM_LANE or below
      if (take_pay) begin
        payload_out <= data_in;
        payload_be  <= be_d;
        rem_q       <= (rem_q > 18'(NUM_LANE)) ?
                       rem_q - 18'(NUM_LANE) : 18'd0;
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_parser.sv
// Directed bench for csi_rx_packet_parser, NUM_LANE=2.
// Lane 0 (low byte of each word) is the earliest byte.
module tb_csi_rx_packet_parser;

  logic        byte_clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] data_in;
  logic        valid_in;
  logic        wait_for_sync;
  logic        packet_done;
  logic        hdr_valid;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] payload_out;
  logic [1:0]  payload_be;
  logic        payload_valid;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;

  always #5 byte_clock = ~byte_clock;

  csi_rx_packet_parser #(.NUM_LANE(2)) dut (
    .byte_clock      (byte_clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .wait_for_sync   (wait_for_sync),
    .packet_done     (packet_done),
    .hdr_valid       (hdr_valid),
    .virtual_channel (virtual_channel),
    .data_type       (data_type),
    .word_count      (word_count),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .payload_out     (payload_out),
    .payload_be      (payload_be),
    .payload_valid   (payload_valid),
    .pkt_err         (pkt_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge byte_clock);
    #1;
  endtask

  task automatic pay(input string tag, input logic [15:0] d,
                     input logic [1:0] be, input logic done);
    cyc(1'b1, d);
    check({tag, "_pv"}, 32'(payload_valid), 32'd1);
    check({tag, "_out"}, 32'(payload_out), 32'(d));
    check({tag, "_be"}, 32'(payload_be), 32'(be));
    check({tag, "_pd"}, 32'(packet_done), 32'(done));
  endtask

  task automatic idle_chk(input string tag);
    cyc(1'b0, 16'h0000);
    check({tag, "_wfs"}, 32'(wait_for_sync), 32'd1);
    check({tag, "_pd"}, 32'(packet_done), 32'd0);
    check({tag, "_pv"}, 32'(payload_valid), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) begin
      @(posedge byte_clock);
      #1;
    end
    check("rst_wfs", 32'(wait_for_sync), 32'd1);
    check("rst_pd", 32'(packet_done), 32'd0);
    check("rst_hv", 32'(hdr_valid), 32'd0);
    check("rst_pv", 32'(payload_valid), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_fields", {virtual_channel, data_type, word_count}, 32'd0);
    check("rst_pay", {payload_out, 14'd0, payload_be}, 32'd0);
    check("rst_fsfe", {frame_start, frame_end}, 32'd0);
    reset_n = 1'b1;
    idle_chk("idle0");

    // short FS, frame number 7
    cyc(1'b1, 16'h0700);
    check("fs_h1_wfs", 32'(wait_for_sync), 32'd0);
    check("fs_h1_hv", 32'(hdr_valid), 32'd0);
    cyc(1'b1, 16'h3C00);
    check("fs_hv", 32'(hdr_valid), 32'd1);
    check("fs_dt", 32'(data_type), 32'h00);
    check("fs_wc", 32'(word_count), 32'h0007);
    check("fs_fsfe", {frame_start, frame_end}, 32'b10);
    check("fs_pd", 32'(packet_done), 32'd1);
    check("fs_wfs", 32'(wait_for_sync), 32'd0);
    idle_chk("fs_end");
    check("fs_hv_clr", 32'(hdr_valid), 32'd0);

    // short FE, VC=1, data field 0x1234
    cyc(1'b1, 16'h3441);
    cyc(1'b1, 16'hAA12);
    check("fe_fsfe", {frame_start, frame_end}, 32'b01);
    check("fe_vc", 32'(virtual_channel), 32'd1);
    check("fe_wc", 32'(word_count), 32'h1234);
    idle_chk("fe_end");

    // long DT=0x2B WC=6
    cyc(1'b1, 16'h062B);
    cyc(1'b1, 16'hEE00);
    check("l6_hv", 32'(hdr_valid), 32'd1);
    check("l6_dt", 32'(data_type), 32'h2B);
    check("l6_wc", 32'(word_count), 32'd6);
    check("l6_fsfe", {frame_start, frame_end}, 32'b00);
    check("l6_pd0", 32'(packet_done), 32'd0);
    pay("l6_w1", 16'hA1A0, 2'b11, 1'b0);
    pay("l6_w2", 16'hB1B0, 2'b11, 1'b0);
    pay("l6_w3", 16'hC1C0, 2'b11, 1'b0);
    pay("l6_w4", 16'hD1D0, 2'b00, 1'b1);
    idle_chk("l6_end");

    // long WC=5
    cyc(1'b1, 16'h052B);
    cyc(1'b1, 16'h0000);
    check("l5_wc", 32'(word_count), 32'd5);
    pay("l5_w1", 16'h1211, 2'b11, 1'b0);
    pay("l5_w2", 16'h1413, 2'b11, 1'b0);
    pay("l5_w3", 16'h1615, 2'b01, 1'b0);
    pay("l5_w4", 16'h1817, 2'b00, 1'b1);
    idle_chk("l5_end");

    // long WC=0: one CRC-only word
    cyc(1'b1, 16'h002B);
    cyc(1'b1, 16'h0000);
    pay("l0_w1", 16'h5A5A, 2'b00, 1'b1);
    idle_chk("l0_end");

    // WC=100, valid drops after one payload word
    cyc(1'b1, 16'h642B);
    cyc(1'b1, 16'h0000);
    pay("ab_w1", 16'h2221, 2'b11, 1'b0);
    cyc(1'b0, 16'h0000);
    check("ab_err", 32'(pkt_err), 32'd1);
    check("ab_pd", 32'(packet_done), 32'd1);
    check("ab_pv", 32'(payload_valid), 32'd0);
    idle_chk("ab_end");
    check("ab_err_clr", 32'(pkt_err), 32'd0);

    // valid drops mid-header
    cyc(1'b1, 16'h0100);
    cyc(1'b0, 16'h0000);
    check("hab_err", 32'(pkt_err), 32'd1);
    check("hab_pd", 32'(packet_done), 32'd1);
    check("hab_hv", 32'(hdr_valid), 32'd0);
    idle_chk("hab_end");

    // enable low after header and mid-payload, WC=6
    cyc(1'b1, 16'h062B);
    cyc(1'b1, 16'h0000);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 16'hFFFF);
      check("en_hv_hold", 32'(hdr_valid), 32'd1);
      check("en_pv_hold", 32'(payload_valid), 32'd0);
    end
    enable = 1'b1;
    pay("en_w1", 16'h3231, 2'b11, 1'b0);
    check("en_hv_clr", 32'(hdr_valid), 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'hBEEF);
      check("en_pv_frz", 32'(payload_valid), 32'd1);
      check("en_out_frz", 32'(payload_out), 32'h3231);
      check("en_pd_frz", 32'(packet_done), 32'd0);
    end
    enable = 1'b1;
    pay("en_w2", 16'h3433, 2'b11, 1'b0);
    pay("en_w3", 16'h3635, 2'b11, 1'b0);
    pay("en_w4", 16'h3837, 2'b00, 1'b1);
    enable = 1'b0;
    cyc(1'b0, 16'h0000);
    check("en_pd_held", 32'(packet_done), 32'd1);
    enable = 1'b1;
    idle_chk("en_end");

    // reset mid-header aborts silently
    cyc(1'b1, 16'h0900);
    check("rh_wfs0", 32'(wait_for_sync), 32'd0);
    reset_n = 1'b0;
    cyc(1'b1, 16'h0000);
    check("rh_wfs", 32'(wait_for_sync), 32'd1);
    check("rh_pd", 32'(packet_done), 32'd0);
    check("rh_err", 32'(pkt_err), 32'd0);
    check("rh_hv", 32'(hdr_valid), 32'd0);
    reset_n = 1'b1;
    cyc(1'b1, 16'h0700);
    check("rh_h1_hv", 32'(hdr_valid), 32'd0);
    cyc(1'b1, 16'h0000);
    check("rh_hv2", 32'(hdr_valid), 32'd1);
    check("rh_wc", 32'(word_count), 32'd7);
    check("rh_fs", 32'(frame_start), 32'd1);
    idle_chk("rh_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi_rx_packet_parser.md
Name: csi_rx_packet_parser

Overview:
- Consumes the lane-aligned word stream from the CSI-2 word aligner, parses the 4-byte packet header and strips the 2-byte CRC footer.
- Forwards long-packet payload bytes with per-byte enables.
- Issues the one-cycle packet_done and wait_for_sync controls back to the word and byte aligners, re-arming them for the next SoT.
- Sits between the word aligner and the ISP/unpacker.

Parameters:
- NUM_LANE, 2, number of D-PHY data lanes; legal values 1, 2, 4. Byte of lane 0 is the earliest byte in each word.

Ports:
- byte_clock  in  1  byte clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  active-1 clock enable; when 0, all state and outputs hold.
- data_in  in  8*NUM_LANE  aligned word; lane i occupies bits [8i+7:8i].
- valid_in  in  1  word-aligner valid; the first valid word carries the header start.
- wait_for_sync  out  1  1 while parser is in IDLE, telling aligners to search for sync.
- packet_done  out  1  one-cycle pulse at end of packet or abort.
- hdr_valid  out  1  one-cycle pulse when header fields are updated.
- virtual_channel  out  2  DI[7:6] of the last header.
- data_type  out  6  DI[5:0] of the last header.
- word_count  out  16  {WC_hi, WC_lo} of the last header; for short packets, the 16-bit data field.
- frame_start  out  1  pulse with hdr_valid when data_type==0x00.
- frame_end  out  1  pulse with hdr_valid when data_type==0x01.
- payload_out  out  8*NUM_LANE  payload word, same lane mapping as data_in.
- payload_be  out  NUM_LANE  per-byte enable; 1 = payload byte, 0 = CRC or padding.
- payload_valid  out  1  payload_out/payload_be qualify.
- pkt_err  out  1  one-cycle pulse when valid_in drops before the packet completes.

Behaviour:
- Reset (reset_n==0 at edge):
  - State goes to IDLE; all outputs 0 except wait_for_sync=1.
  - Header byte counter and remaining-byte counter cleared.
  - Reset mid-packet aborts silently: no packet_done, no pkt_err.
- States: IDLE, HEADER, PAYLOAD, DONE. Transitions below happen only on cycles with enable==1.
- IDLE:
  - wait_for_sync=1.
  - On valid_in==1, latch NUM_LANE header bytes in lane order.
  - If 4 bytes are collected, decode; otherwise go to HEADER.
- HEADER:
  - Collect NUM_LANE bytes per valid word until 4 bytes are held (2 words for NUM_LANE=2, 4 words for NUM_LANE=1).
  - valid_in==0 here: pkt_err=1, go to DONE.
- Decode, registered on the cycle after the last header byte:
  - hdr_valid=1; header fields updated; frame_start/frame_end pulse as defined.
  - ECC byte is not checked.
  - Long packet (data_type >= 0x10): rem <= word_count+2 (18-bit, no overflow); go to PAYLOAD.
  - Short packet: go to DONE.
- PAYLOAD:
  - Each valid word produces payload_valid=1 next cycle, with payload_out = data_in.
  - payload_be[i] = (i < rem-2) for that word, saturating at 0.
  - Words containing only CRC bytes still assert payload_valid with payload_be=0.
  - rem <= rem-NUM_LANE; if rem <= NUM_LANE, go to DONE.
  - valid_in==0 before completion: pkt_err=1, no payload_valid, go to DONE.
- DONE:
  - packet_done=1 and wait_for_sync=0 for exactly one cycle; data_in is ignored.
  - Next state is IDLE.
- Pulse timing: hdr_valid, frame_start, frame_end and pkt_err are registered pulses of one enabled cycle.
- Latency: valid_in/data_in to payload_out is 1 cycle.
- word_count==0 long packet: rem=2; one CRC-only word (NUM_LANE=2), then DONE.
- enable==0 for N cycles mid-packet: state, counters and pulses freeze; pulse outputs are held, not repeated.

Test Plan:
- NUM_LANE=2, reset_n low 3 cycles → wait_for_sync=1, all other outputs 0.
- Short packet FS: words {0x00,0x00},{0x00,0xXX} with valid → hdr_valid=1, data_type=0x00, frame_start=1, then packet_done one cycle, then wait_for_sync=1.
- Long packet DT=0x2B, WC=6 (header 0x2B,0x06,0x00,ecc), then 4 words → payload_be 11,11,11,00; packet_done in the cycle after the 4th word; no extra payload_valid.
- Long packet WC=5 → payload_be 11,11,01, then the 4th word is CRC-only with be=00.
- valid_in drops after 1 payload word of WC=100 → pkt_err=1 and packet_done=1 in the same DONE cycle, then IDLE.
- enable low 3 cycles mid-payload, plus reset_n asserted mid-header → state holds with no duplicate pulses; on reset, returns to IDLE with no packet_done.
